// File: rtl/dcache_pkg.sv
// Shared data-cache definitions: miss FSM states and default geometry.
package dcache_pkg;

  // Miss handler states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WB   = 2'd1,
    ST_RD   = 2'd2,
    ST_DONE = 2'd3
  } refill_state_e;

  // Default geometry, shared with the cache arrays and the hazard unit.
  localparam int unsigned DEF_ADDR_W     = 32;
  localparam int unsigned DEF_LINE_WORDS = 4;

endpackage

// File: rtl/dcache_refill_ctrl.sv
// Data-cache miss handler: optional dirty-victim writeback, then line refill
// from a word-addressed one-cycle synchronous memory, with pipeline stall.
module dcache_refill_ctrl
  import dcache_pkg::*;
#(
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
  parameter int unsigned OFF_W      = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_req,
  input  logic [ADDR_W-1:0] miss_addr,
  input  logic              victim_dirty,
  input  logic [ADDR_W-1:0] victim_addr,
  output logic [OFF_W-1:0]  wb_idx,
  input  logic [31:0]       wb_data,
  output logic              fill_we,
  output logic [OFF_W-1:0]  fill_idx,
  output logic [31:0]       fill_data,
  output logic              fill_done,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // Counter end points: writeback stops at the last word, the read phase
  // runs one extra cycle to catch the final word's read data.
  localparam logic [OFF_W:0]    CNT_ONE     = (OFF_W+1)'(1);
  localparam logic [OFF_W:0]    CNT_WB_LAST = (OFF_W+1)'(LINE_WORDS - 1);
  localparam logic [OFF_W:0]    CNT_RD_END  = (OFF_W+1)'(LINE_WORDS);
  localparam logic [OFF_W-1:0]  IDX_ONE     = OFF_W'(1);
  localparam logic [ADDR_W-1:0] OFF_MASK    = ADDR_W'(LINE_WORDS - 1);

  refill_state_e     state_q, state_d;
  logic [OFF_W:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0] fill_base_q, fill_base_d;
  logic [ADDR_W-1:0] wb_base_q, wb_base_d;

  // State, burst counter and latched line bases; reset aborts any burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      fill_base_q <= '0;
      wb_base_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fill_base_q <= fill_base_d;
      wb_base_q   <= wb_base_d;
    end
  end

  // Next-state, counter sequencing and per-state memory/fill outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_base_d = fill_base_q;
    wb_base_d   = wb_base_q;
    wb_idx      = '0;
    fill_we     = 1'b0;
    fill_idx    = '0;
    fill_data   = 32'h0000_0000;
    fill_done   = 1'b0;
    mem_en      = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = '0;
    mem_wdata   = 32'h0000_0000;
    case (state_q)
      ST_IDLE: begin
        if (miss_req) begin
          fill_base_d = miss_addr & ~OFF_MASK;
          wb_base_d   = victim_addr;
          cnt_d       = '0;
          state_d     = victim_dirty ? ST_WB : ST_RD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WB: begin
        mem_en    = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = wb_base_q + ADDR_W'(cnt_q);
        wb_idx    = cnt_q[OFF_W-1:0];
        mem_wdata = wb_data;
        if (cnt_q == CNT_WB_LAST) begin
          cnt_d   = '0;
          state_d = ST_RD;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RD: begin
        // Read word cnt while installing the word read in the previous cycle.
        if (cnt_q < CNT_RD_END) begin
          mem_en   = 1'b1;
          mem_addr = fill_base_q + ADDR_W'(cnt_q);
        end else begin
          mem_en = 1'b0;
        end
        if (cnt_q != '0) begin
          fill_we   = 1'b1;
          fill_idx  = cnt_q[OFF_W-1:0] - IDX_ONE;
          fill_data = mem_rdata;
        end else begin
          fill_we = 1'b0;
        end
        if (cnt_q == CNT_RD_END) begin
          cnt_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_DONE: begin
        fill_done = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // Stall follows the request immediately and holds until the line is in.
  assign busy = miss_req | (state_q != ST_IDLE);

endmodule
